// File: rtl/mem_line_responder.sv
// Line-granular memory responder: byte-masked line writes, fixed-latency in-order read responses.
module mem_line_responder #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_BITS  = 128,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_req_valid,
    output logic                    mem_req_ready,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_req_rw,
    input  logic                    mem_req_data_valid,
    output logic                    mem_req_data_ready,
    input  logic [DATA_BITS-1:0]    mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0]  mem_req_data_mask,
    output logic                    mem_resp_valid,
    output logic [DATA_BITS-1:0]    mem_resp_data
);

    localparam int unsigned MASK_BITS = DATA_BITS / 8;
    localparam int unsigned DEPTH     = 32'(1) << DEPTH_LOG2;
    localparam int unsigned CNT_W     = $clog2(MAX_OUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_n;
    logic [DEPTH_LOG2-1:0]  wr_addr_q;
    logic [CNT_W-1:0]       rd_count_q;
    logic [CNT_W-1:0]       rd_count_n;
    logic                   req_ready_q;

    logic [DATA_BITS-1:0]   mem [DEPTH];

    logic [LATENCY-1:0]     pipe_v_q;
    logic [DATA_BITS-1:0]   pipe_d_q [LATENCY];

    logic                   req_fire_c;
    logic                   rd_accept_c;
    logic                   wr_commit_c;
    logic                   latch_addr_c;
    logic [DEPTH_LOG2-1:0]  req_idx_c;
    logic [DEPTH_LOG2-1:0]  wr_idx_c;

    // Upper address bits alias onto the stored lines and are deliberately dropped.
    assign req_idx_c = mem_req_addr[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    assign mem_req_ready  = req_ready_q;
    assign mem_resp_valid = pipe_v_q[LATENCY-1];
    assign mem_resp_data  = pipe_d_q[LATENCY-1];

    // Next-state, handshake and commit decode.
    always_comb begin
        state_n            = state_q;
        rd_accept_c        = 1'b0;
        wr_commit_c        = 1'b0;
        latch_addr_c       = 1'b0;
        wr_idx_c           = wr_addr_q;
        mem_req_data_ready = 1'b0;
        req_fire_c         = mem_req_valid & req_ready_q;

        case (state_q)
            IDLE: begin
                if (req_fire_c) begin
                    if (mem_req_rw) begin
                        mem_req_data_ready = 1'b1;
                        if (mem_req_data_valid) begin
                            wr_commit_c = 1'b1;
                            wr_idx_c    = req_idx_c;
                        end else begin
                            latch_addr_c = 1'b1;
                            state_n      = WDATA;
                        end
                    end else begin
                        rd_accept_c = 1'b1;
                    end
                end
            end
            WDATA: begin
                mem_req_data_ready = 1'b1;
                if (mem_req_data_valid) begin
                    wr_commit_c = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // An accept and a response in the same cycle cancel out.
        rd_count_n = rd_count_q + CNT_W'(rd_accept_c) - CNT_W'(pipe_v_q[LATENCY-1]);
    end

    // Control state; ready is registered from the next-cycle state and count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_count_q  <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            rd_count_q  <= rd_count_n;
            req_ready_q <= (state_n == IDLE) && (rd_count_n < CNT_W'(MAX_OUT));
            if (latch_addr_c) begin
                wr_addr_q <= req_idx_c;
            end
        end
    end

    // Read latency pipeline; data is snapshotted at accept and zero when not valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                pipe_d_q[k] <= '0;
            end
        end else begin
            pipe_v_q[0] <= rd_accept_c;
            pipe_d_q[0] <= rd_accept_c ? mem[req_idx_c] : '0;
            for (int k = 1; k < int'(LATENCY); k++) begin
                pipe_v_q[k] <= pipe_v_q[k-1];
                pipe_d_q[k] <= pipe_d_q[k-1];
            end
        end
    end

    // Storage array with byte-masked commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit_c) begin
            for (int b = 0; b < int'(MASK_BITS); b++) begin
                if (mem_req_data_mask[b]) begin
                    mem[wr_idx_c][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
                end
            end
        end
    end

endmodule
